// File: rtl/fetch_if_if.sv
// Instruction-memory request/response channel between the fetch stage and memory.
interface fetch_if_if;
  logic        ireq_valid;
  logic        ireq_ready;
  logic [63:0] ireq_addr;
  logic        iresp_valid;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  ireq_ready,
    input  iresp_valid,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output ireq_ready,
    output iresp_valid,
    output iresp_data
  );
endinterface

// File: rtl/fetch_if.sv
// Instruction fetch stage: issues one request at a time to instruction memory,
// parks a response in a single-entry hold buffer while decode stalls, and
// squashes in-flight fetches on an execute-stage redirect.
module fetch_if #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if_if.master  imem,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [63:0] PCTargetE,
  output logic [31:0] instrD,
  output logic [63:0] PCD,
  output logic [63:0] PCPlus4D,
  output logic        enableD,
  output logic        misalignF
);

  typedef enum logic [1:0] {
    stReq  = 2'd0,
    stWait = 2'd1,
    stHold = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, stateNext;
  logic [63:0] PCF, pcNext;
  logic        started;
  logic        drop, dropNext;
  logic [31:0] holdInstr, holdInstrNext;
  logic [63:0] holdPc, holdPcNext;
  logic        holdValid, holdValidNext;
  logic [31:0] instrNext;
  logic [63:0] pcdNext, pcPlus4Next;
  logic        enableNext;
  logic        misalignNext;
  logic        accept;
  logic        slotFree;

  // started keeps the first request off the bus until the first edge after reset
  assign imem.ireq_valid = (state == stReq) && started;
  assign imem.ireq_addr  = PCF;
  assign accept          = imem.ireq_valid && imem.ireq_ready;
  assign slotFree        = !enableD || !StallD;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= stReq;
      started   <= 1'b0;
      PCF       <= RESET_PC;
      drop      <= 1'b0;
      holdInstr <= NOP;
      holdPc    <= '0;
      holdValid <= 1'b0;
      instrD    <= NOP;
      PCD       <= '0;
      PCPlus4D  <= '0;
      enableD   <= 1'b0;
      misalignF <= 1'b0;
    end else begin
      state     <= stateNext;
      started   <= 1'b1;
      PCF       <= pcNext;
      drop      <= dropNext;
      holdInstr <= holdInstrNext;
      holdPc    <= holdPcNext;
      holdValid <= holdValidNext;
      instrD    <= instrNext;
      PCD       <= pcdNext;
      PCPlus4D  <= pcPlus4Next;
      enableD   <= enableNext;
      misalignF <= misalignNext;
    end
  end

  // Next-state and next-register logic; a redirect overrides every other event
  always_comb begin
    stateNext     = state;
    pcNext        = PCF;
    dropNext      = drop;
    holdInstrNext = holdInstr;
    holdPcNext    = holdPc;
    holdValidNext = holdValid;
    instrNext     = instrD;
    pcdNext       = PCD;
    pcPlus4Next   = PCPlus4D;
    enableNext    = enableD;
    misalignNext  = 1'b0;

    if (PCSrcE) begin
      pcNext        = {PCTargetE[63:2], 2'b00};
      enableNext    = 1'b0;
      holdValidNext = 1'b0;
      misalignNext  = |PCTargetE[1:0];
      unique case (state)
        stReq: begin
          if (accept) begin
            // the request just accepted targets the old path; squash its response
            stateNext = stWait;
            dropNext  = 1'b1;
          end else begin
            stateNext = stReq;
          end
        end
        stWait: begin
          if (imem.iresp_valid) begin
            stateNext = stReq;
            dropNext  = 1'b0;
          end else begin
            stateNext = stWait;
            dropNext  = 1'b1;
          end
        end
        default: stateNext = stReq;
      endcase
    end else begin
      // decode consumed its instruction; a load below overrides this
      if (enableD && !StallD) enableNext = 1'b0;
      unique case (state)
        stReq: begin
          if (accept) stateNext = stWait;
        end
        stWait: begin
          if (imem.iresp_valid) begin
            if (drop) begin
              dropNext  = 1'b0;
              stateNext = stReq;
            end else if (slotFree) begin
              instrNext   = imem.iresp_data;
              pcdNext     = PCF;
              pcPlus4Next = PCF + 64'd4;
              enableNext  = 1'b1;
              pcNext      = PCF + 64'd4;
              stateNext   = stReq;
            end else begin
              holdInstrNext = imem.iresp_data;
              holdPcNext    = PCF;
              holdValidNext = 1'b1;
              pcNext        = PCF + 64'd4;
              stateNext     = stHold;
            end
          end
        end
        stHold: begin
          if (!StallD) begin
            instrNext     = holdInstr;
            pcdNext       = holdPc;
            pcPlus4Next   = holdPc + 64'd4;
            enableNext    = holdValid;
            holdValidNext = 1'b0;
            stateNext     = stReq;
          end
        end
        default: stateNext = stReq;
      endcase
    end
  end

endmodule
